uart_tx_arbiter: RTL and testbench

Shares one sn_uart_tx transmitter among P_NUM_REQ byte sources, such as the echo path, status reporter and debug dump. Requests are served round-robin, one byte per grant. The block drives the transmitter's level-held tx_enable and data, and releases the transmitter on tx_done. It sits between the requesting blocks and sn_uart_tx inside comms-level top modules.

---
 rtl/uart_arb_pkg.sv | 19 +
 rtl/uart_rr_pick.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmitter arbiter and its round-robin picker.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_GAP_CLKS     = 2;
  localparam int DEF_TIMEOUT_CLKS = 3480;

  // Index width for n requesters; a single requester still gets a 1-bit id.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: the first set request after last_i, wrapping, wins.
module uart_rr_pick #(
  parameter int P_NUM_REQ = 4,
  parameter int P_ID_W    = 2
) (
  input  logic [P_NUM_REQ-1:0] req_i,
  input  logic [P_ID_W-1:0]    last_i,
  output logic                 valid_o,
  output logic [P_ID_W-1:0]    winner_o,
  output logic [P_NUM_REQ-1:0] onehot_o
);

  logic [P_ID_W-1:0] idx_s;
  logic              hit_s;

  // Offset 1 (the requester right after last) is scanned first, so it has top priority.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    idx_s    = '0;
    hit_s    = 1'b0;
    for (int k = 1; k <= P_NUM_REQ; k++) begin
      idx_s    = P_ID_W'((int'(last_i) + k) % P_NUM_REQ);
      hit_s    = req_i[idx_s] & ~valid_o;
      winner_o = hit_s ? idx_s : winner_o;
      valid_o  = valid_o | hit_s;
    end
  end

  assign onehot_o = valid_o ? (P_NUM_REQ'(1) << winner_o) : '0;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among P_NUM_REQ byte sources.
// Optional SEND watchdog is built only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int  P_NUM_REQ      = 4,
  parameter int  P_DATA_W       = DEF_DATA_W,
  parameter int  P_GAP_CLKS     = DEF_GAP_CLKS,
  parameter int  P_TIMEOUT_CLKS = DEF_TIMEOUT_CLKS,
  localparam int ID_W           = id_width(P_NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [P_NUM_REQ-1:0]          req,
  input  logic [P_NUM_REQ*P_DATA_W-1:0] req_data,
  output logic [P_NUM_REQ-1:0]          grant,
  output logic                          tx_enable,
  output logic [P_DATA_W-1:0]           tx_data,
  input  logic                          tx_done,
  output logic                          busy,
  output logic [ID_W-1:0]               active_id,
  output logic                          timeout_err
);

  localparam int             GAP_W    = (P_GAP_CLKS > 1) ? $clog2(P_GAP_CLKS) : 1;
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(P_NUM_REQ - 1);

  arb_state_e             state_q;
  logic [P_NUM_REQ-1:0]   grant_q;
  logic                   tx_en_q;
  logic [P_DATA_W-1:0]    tx_data_q;
  logic                   busy_q;
  logic [ID_W-1:0]        last_q;
  logic [ID_W-1:0]        active_id_q;
  logic [GAP_W-1:0]       gap_cnt_q;

  logic                   pick_valid_s;
  logic [ID_W-1:0]        pick_id_s;
  logic [P_NUM_REQ-1:0]   pick_onehot_s;
  logic                   to_hit_s;

  uart_rr_pick #(
    .P_NUM_REQ (P_NUM_REQ),
    .P_ID_W    (ID_W)
  ) u_pick (
    .req_i    (req),
    .last_i   (last_q),
    .valid_o  (pick_valid_s),
    .winner_o (pick_id_s),
    .onehot_o (pick_onehot_s)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_W = (P_TIMEOUT_CLKS > 1) ? $clog2(P_TIMEOUT_CLKS) : 1;

  logic [TO_W-1:0] to_cnt_q;
  logic            err_q;

  // SEND watchdog: restarts every frame; a simultaneous tx_done counts as normal completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else if (state_q == SEND) begin
      to_cnt_q <= to_hit_s ? '0 : to_cnt_q + TO_W'(1);
      err_q    <= to_hit_s & ~tx_done;
    end else begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end
  end

  assign to_hit_s    = (to_cnt_q == TO_W'(P_TIMEOUT_CLKS - 1));
  assign timeout_err = err_q;
`else
  assign to_hit_s    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Frame FSM; req is only looked at in IDLE, so pending requests wait out SEND and GAP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      tx_en_q     <= 1'b0;
      tx_data_q   <= '0;
      busy_q      <= 1'b0;
      last_q      <= LAST_RST;
      active_id_q <= '0;
      gap_cnt_q   <= '0;
    end else begin
      grant_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_valid_s) begin
            state_q     <= SEND;
            grant_q     <= pick_onehot_s;
            tx_en_q     <= 1'b1;
            tx_data_q   <= req_data[pick_id_s*P_DATA_W +: P_DATA_W];
            last_q      <= pick_id_s;
            active_id_q <= pick_id_s;
            busy_q      <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        SEND: begin
          if (tx_done || to_hit_s) begin
            tx_en_q   <= 1'b0;
            gap_cnt_q <= '0;
            if (P_GAP_CLKS == 0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= GAP;
            end
          end else begin
            state_q <= SEND;
          end
        end
        GAP: begin
          if (int'(gap_cnt_q) >= P_GAP_CLKS - 1) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            gap_cnt_q <= '0;
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          tx_en_q   <= 1'b0;
          busy_q    <= 1'b0;
          gap_cnt_q <= '0;
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign tx_enable = tx_en_q;
  assign tx_data   = tx_data_q;
  assign busy      = busy_q;
  assign active_id = active_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, corner sequences, random frames vs. a model.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int GAP = 2;
  localparam int TMO = 3480;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic          tx_done = 1'b0;
  logic [N-1:0]  grant;
  logic          tx_enable;
  logic [DW-1:0] tx_data;
  logic          busy;
  logic [1:0]    active_id;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0] req;
    logic [7:0]   base;
    int           hold;
    logic [N-1:0] exp_grant;
    logic [7:0]   exp_data;
    logic [1:0]   exp_id;
  } vec_t;

  vec_t vecs [10];

  uart_tx_arbiter #(
    .P_NUM_REQ      (N),
    .P_DATA_W       (DW),
    .P_GAP_CLKS     (GAP),
    .P_TIMEOUT_CLKS (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .grant       (grant),
    .tx_enable   (tx_enable),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy),
    .active_id   (active_id),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Requester i presents base+i; only the winner's byte should reach tx_data.
  task automatic set_req(input logic [N-1:0] r, input logic [7:0] base);
    req = r;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = base + 8'(i);
  endtask

  // Round-robin reference: the set bit with the smallest circular distance after last wins.
  function automatic int model_pick(input logic [N-1:0] m, input int last);
    int best;
    int best_d;
    int d;
    best   = -1;
    best_d = N + 1;
    for (int i = 0; i < N; i++) begin
      d = (i - last - 1 + 2 * N) % N;
      if (m[i] && d < best_d) begin
        best_d = d;
        best   = i;
      end
    end
    return best;
  endfunction

  // One full frame from an idle arbiter: grant, hold, tx_done, two GAP clocks, back to idle.
  task automatic run_frame(input string tag, input logic [N-1:0] r, input logic [7:0] base,
                           input int hold, input logic [N-1:0] eg, input logic [7:0] ed,
                           input logic [1:0] eid);
    logic held;
    held = 1'b1;
    set_req(r, base);
    step();
    chk({tag, "_grant"}, grant, eg);
    chk({tag, "_txen"}, tx_enable, 1);
    chk({tag, "_data"}, tx_data, ed);
    chk({tag, "_id"}, active_id, eid);
    chk({tag, "_busy"}, busy, 1);
    set_req('0, ~base);
    step();
    chk({tag, "_grant_pulse"}, grant, 0);
    for (int i = 1; i < hold; i++) begin
      step();
      if (tx_enable !== 1'b1 || tx_data !== ed || grant !== '0 || timeout_err !== 1'b0) held = 1'b0;
    end
    chk({tag, "_hold"}, held, 1);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk({tag, "_release"}, {busy, tx_enable, grant}, 6'b100000);
    set_req('1, base);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk({tag, "_gap2"}, {busy, tx_enable, grant}, 6'b100000);
    step();
    chk({tag, "_idle"}, {busy, tx_enable, grant}, 6'b000000);
    set_req('0, base);
  endtask

  initial begin
    logic [N-1:0] m;
    logic [7:0]   b;
    int           h;
    int           w;
    int           n;
    int           model_last;
    logic         ok;

    vecs[0] = '{4'b0001, 8'hA5, 870, 4'b0001, 8'hA5, 2'd0};
    vecs[1] = '{4'b1111, 8'h10, 5,   4'b0010, 8'h11, 2'd1};
    vecs[2] = '{4'b1111, 8'h20, 5,   4'b0100, 8'h22, 2'd2};
    vecs[3] = '{4'b1111, 8'h30, 5,   4'b1000, 8'h33, 2'd3};
    vecs[4] = '{4'b1111, 8'h40, 5,   4'b0001, 8'h40, 2'd0};
    vecs[5] = '{4'b1010, 8'h50, 3,   4'b0010, 8'h51, 2'd1};
    vecs[6] = '{4'b1001, 8'h60, 4,   4'b1000, 8'h63, 2'd3};
    vecs[7] = '{4'b1001, 8'h70, 2,   4'b0001, 8'h70, 2'd0};
    vecs[8] = '{4'b0100, 8'h80, 6,   4'b0100, 8'h82, 2'd2};
    vecs[9] = '{4'b0110, 8'h90, 2,   4'b0010, 8'h91, 2'd1};

    #12;
    chk("reset_outs", {grant, tx_enable, busy, timeout_err}, 0);
    chk("reset_data", tx_data, 0);
    chk("reset_id", active_id, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].req, vecs[i].base, vecs[i].hold,
                vecs[i].exp_grant, vecs[i].exp_data, vecs[i].exp_id);
    end
    model_last = 1;

    // Stray tx_done while idle must not start anything.
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    step();
    chk("idle_done", {busy, tx_enable, grant}, 6'b000000);

    for (int it = 0; it < 40; it++) begin
      m = 4'($urandom_range(0, 15));
      b = 8'($urandom_range(0, 255));
      h = $urandom_range(2, 30);
      if (m == '0) begin
        set_req('0, b);
        step();
        step();
        chk("rnd_none", {busy, tx_enable, grant}, 6'b000000);
      end else begin
        w = model_pick(m, model_last);
        run_frame($sformatf("rnd%0d", it), m, b, h, 4'(1 << w), b + 8'(w), 2'(w));
        model_last = w;
      end
    end

    // Asynchronous reset during SEND clears outputs before any clock edge.
    set_req(4'b0001, 8'hC0);
    step();
    chk("rst_pre_grant", grant, 4'b0001);
    #2 rst = 1'b0;
    #1;
    chk("rst_async", {grant, tx_enable, busy, timeout_err}, 0);
    chk("rst_async_data", tx_data, 0);
    chk("rst_async_id", active_id, 0);
    set_req('0, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_frame("rst_rel", 4'b0110, 8'hD0, 4, 4'b0010, 8'hD1, 2'd1);

`ifdef UART_ARB_TIMEOUT_EN
    set_req(4'b0001, 8'hE0);
    step();
    chk("to_grant", grant, 4'b0001);
    set_req(4'b0110, 8'hF0);
    n = 0;
    while (timeout_err !== 1'b1 && n < TMO + 100) begin
      step();
      n++;
    end
    chk("to_cycles", n, TMO);
    chk("to_txen", tx_enable, 0);
    step();
    chk("to_pulse", {timeout_err, busy}, 2'b01);
    step();
    chk("to_gap_end", busy, 0);
    step();
    chk("to_next_grant", grant, 4'b0010);
    chk("to_next_data", tx_data, 8'hF1);
    set_req('0, 8'h00);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    repeat (3) step();
    chk("to_done", {busy, tx_enable}, 2'b00);
`else
    set_req(4'b0001, 8'hE0);
    step();
    chk("nto_grant", grant, 4'b0001);
    set_req('0, 8'h00);
    ok = 1'b1;
    repeat (TMO + 100) begin
      step();
      if (tx_enable !== 1'b1 || timeout_err !== 1'b0) ok = 1'b0;
    end
    chk("nto_wait", ok, 1);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    repeat (2) step();
    chk("nto_done", {busy, tx_enable}, 2'b00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
